// File: rtl/data_bus_pkg.sv
// Shared types and constants for the DATA/data_sb bus arbiter.
// Build option DATA_BUS_ARB_RR_EN selects round-robin arbitration (fixed priority otherwise).
package data_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_GAP    = 2'd3
    } state_e;

    localparam int BUS_W      = 8;
    localparam int CH_SEL_BIT = 7;
    localparam int N_SRC      = 2;
    localparam int CNT_W      = 4;

    // Bit CH_SEL_BIT of a bus byte steers it to channel A (1) or channel B (0).
    function automatic logic is_chan_a(input logic [BUS_W-1:0] b);
        return b[CH_SEL_BIT];
    endfunction

endpackage

// File: rtl/bus_pick.sv
// Winner select for the two bus requesters, one-hot grant out.
// DATA_BUS_ARB_RR_EN adds a last-grant register and round-robin ties; otherwise source 0 wins ties.
module bus_pick
    import data_bus_pkg::*;
(
`ifdef DATA_BUS_ARB_RR_EN
    input  logic             clk,
    input  logic             rst,
    input  logic             take_i,
`endif
    input  logic             req0_i,
    input  logic             req1_i,
    output logic [N_SRC-1:0] gnt_o
);

`ifdef DATA_BUS_ARB_RR_EN
    // last_q = 1 means source 1 was granted most recently.
    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o = '0;
        if (req0_i && req1_i) begin
            if (last_q) begin
                gnt_o = 2'b01;
            end else begin
                gnt_o = 2'b10;
            end
        end else if (req0_i) begin
            gnt_o = 2'b01;
        end else if (req1_i) begin
            gnt_o = 2'b10;
        end
    end

    always_comb begin
        last_d = last_q;
        if (take_i) begin
            last_d = gnt_o[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        gnt_o = '0;
        if (req0_i) begin
            gnt_o = 2'b01;
        end else if (req1_i) begin
            gnt_o = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/data_bus_arb.sv
// Two-source arbiter/sequencer for the DATA/data_sb bus: setup cycle, strobe of SB_WIDTH, gap of GAP_CYCLES.
// Build option DATA_BUS_ARB_RR_EN selects round-robin arbitration in bus_pick.
module data_bus_arb
    import data_bus_pkg::*;
#(
    parameter int unsigned SB_WIDTH   = 1,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [BUS_W-1:0] data0,
    output logic             ack0,
    input  logic             req1,
    input  logic [BUS_W-1:0] data1,
    output logic             ack1,
    output logic [BUS_W-1:0] DATA,
    output logic             data_sb,
    output logic             busy
);

    // Counter reload values; the counter runs down to zero inside STROBE and GAP.
    localparam logic [CNT_W-1:0] SB_LOAD  = CNT_W'(SB_WIDTH - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [BUS_W-1:0] data_q;
    logic             sb_q;
    logic             ack0_q;
    logic             ack1_q;
    logic             busy_q;

    logic [N_SRC-1:0] gnt;
    logic             in_idle;

    assign in_idle = (state_q == ST_IDLE);

    bus_pick u_pick (
`ifdef DATA_BUS_ARB_RR_EN
        .clk    (clk),
        .rst    (rst),
        .take_i (in_idle && (req0 || req1)),
`endif
        .req0_i (req0 && in_idle),
        .req1_i (req1 && in_idle),
        .gnt_o  (gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            sb_q    <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (gnt[0] || gnt[1]) begin
                        data_q  <= gnt[0] ? data0 : data1;
                        ack0_q  <= gnt[0];
                        ack1_q  <= gnt[1];
                        state_q <= ST_SETUP;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    state_q <= ST_STROBE;
                    sb_q    <= 1'b1;
                    cnt_q   <= SB_LOAD;
                end
                ST_STROBE: begin
                    if (cnt_q == '0) begin
                        sb_q <= 1'b0;
                        if (GAP_CYCLES == 0) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_GAP;
                            cnt_q   <= GAP_LOAD;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    sb_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign DATA    = data_q;
    assign data_sb = sb_q;
    assign ack0    = ack0_q;
    assign ack1    = ack1_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_data_bus_arb.sv
// Directed bench for data_bus_arb: defaults, SB_WIDTH=3/GAP_CYCLES=0, and GAP_CYCLES=3 instances.
// Tie-break expectations follow DATA_BUS_ARB_RR_EN when the bench is built with it.
module tb_data_bus_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // default instance
  logic       rst_a = 1'b1, req0_a = 1'b0, req1_a = 1'b0;
  logic [7:0] data0_a = '0, data1_a = '0;
  logic       ack0_a, ack1_a, sb_a, busy_a;
  logic [7:0] bus_a;

  // SB_WIDTH=3, GAP_CYCLES=0 instance
  logic       rst_b = 1'b1, req0_b = 1'b0, req1_b = 1'b0;
  logic [7:0] data0_b = '0, data1_b = '0;
  logic       ack0_b, ack1_b, sb_b, busy_b;
  logic [7:0] bus_b;

  // GAP_CYCLES=3 instance
  logic       rst_c = 1'b1, req0_c = 1'b0, req1_c = 1'b0;
  logic [7:0] data0_c = '0, data1_c = '0;
  logic       ack0_c, ack1_c, sb_c, busy_c;
  logic [7:0] bus_c;

  logic [7:0] exp_q[$];
  logic       exp_src_q[$];

  data_bus_arb dut (
    .clk(clk), .rst(rst_a), .req0(req0_a), .data0(data0_a), .ack0(ack0_a),
    .req1(req1_a), .data1(data1_a), .ack1(ack1_a), .DATA(bus_a), .data_sb(sb_a), .busy(busy_a)
  );

  data_bus_arb #(.SB_WIDTH(3), .GAP_CYCLES(0)) dut_w3 (
    .clk(clk), .rst(rst_b), .req0(req0_b), .data0(data0_b), .ack0(ack0_b),
    .req1(req1_b), .data1(data1_b), .ack1(ack1_b), .DATA(bus_b), .data_sb(sb_b), .busy(busy_b)
  );

  data_bus_arb #(.SB_WIDTH(1), .GAP_CYCLES(3)) dut_g3 (
    .clk(clk), .rst(rst_c), .req0(req0_c), .data0(data0_c), .ack0(ack0_c),
    .req1(req1_c), .data1(data1_c), .ack1(ack1_c), .DATA(bus_c), .data_sb(sb_c), .busy(busy_c)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // all driving and sampling happens 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n_grants;
    logic [7:0] eb;
    logic       es;

    // ---------------- reset ----------------
    #1;
    tick();
    tick();
    check_val("rst_data_a", bus_a, 8'h00);
    check_val("rst_sb_a", sb_a, 1'b0);
    check_val("rst_busy_a", busy_a, 1'b0);
    check_val("rst_ack_a", {ack0_a, ack1_a}, 2'b00);
    check_val("rst_data_b", bus_b, 8'h00);
    check_val("rst_busy_c", busy_c, 1'b0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("idle_data", bus_a, 8'h00);
      check_val("idle_sb", sb_a, 1'b0);
      check_val("idle_busy", busy_a, 1'b0);
    end

    // ---------------- single transfer, defaults ----------------
    req0_a = 1'b1;
    data0_a = 8'h85;
    tick();
    check_val("t1_ack0", ack0_a, 1'b1);
    check_val("t1_ack1", ack1_a, 1'b0);
    check_val("t1_data", bus_a, 8'h85);
    check_val("t1_setup_sb", sb_a, 1'b0);
    check_val("t1_busy", busy_a, 1'b1);
    req0_a = 1'b0;
    tick();
    check_val("t1_ack_pulse", ack0_a, 1'b0);
    check_val("t1_strobe", sb_a, 1'b1);
    check_val("t1_data_hold", bus_a, 8'h85);
    tick();
    check_val("t1_gap_sb", sb_a, 1'b0);
    check_val("t1_gap_busy", busy_a, 1'b1);
    tick();
    check_val("t1_idle_busy", busy_a, 1'b0);
    check_val("t1_idle_data", bus_a, 8'h85);

    // ---------------- both requests held ----------------
`ifdef DATA_BUS_ARB_RR_EN
    exp_q.push_back(8'h81); exp_src_q.push_back(1'b0);
    exp_q.push_back(8'h02); exp_src_q.push_back(1'b1);
    exp_q.push_back(8'h81); exp_src_q.push_back(1'b0);
`else
    exp_q.push_back(8'h81); exp_src_q.push_back(1'b0);
    exp_q.push_back(8'h81); exp_src_q.push_back(1'b0);
    exp_q.push_back(8'h81); exp_src_q.push_back(1'b0);
`endif
    data0_a = 8'h81;
    data1_a = 8'h02;
    req0_a = 1'b1;
    req1_a = 1'b1;
    n_grants = 0;
    for (int c = 0; c < 40 && n_grants < 3; c++) begin
      tick();
      if (ack0_a || ack1_a) begin
        eb = exp_q.pop_front();
        es = exp_src_q.pop_front();
        check_val("arb_onehot", {ack0_a, ack1_a}, {~es, es});
        check_val("arb_data", bus_a, eb);
        n_grants++;
        if (n_grants == 3) begin
          req0_a = 1'b0;
          req1_a = 1'b0;
        end
      end
    end
    check_val("arb_grants", n_grants, 3);
    for (int c = 0; c < 20 && busy_a; c++) tick();
    check_val("arb_drain", busy_a, 1'b0);

    // ---------------- SB_WIDTH=3, GAP_CYCLES=0 back-to-back ----------------
    req1_b = 1'b1;
    data1_b = 8'h42;
    tick();
    check_val("w3_first_ack", ack1_b, 1'b1);
    check_val("w3_first_data", bus_b, 8'h42);
    for (int k = 1; k <= 15; k++) begin
      tick();
      check_val("w3_sb", sb_b, ((k - 1) % 5) < 3);
      check_val("w3_ack1", ack1_b, (k % 5) == 0);
      if (k == 15) req1_b = 1'b0;
    end
    for (int c = 0; c < 20 && busy_b; c++) tick();
    check_val("w3_drain", busy_b, 1'b0);

    // ---------------- reset during STROBE ----------------
    req0_b = 1'b1;
    data0_b = 8'h99;
    tick();
    check_val("rs_ack0", ack0_b, 1'b1);
    check_val("rs_data", bus_b, 8'h99);
    tick();
    check_val("rs_strobe1", sb_b, 1'b1);
    tick();
    check_val("rs_strobe2", sb_b, 1'b1);
    rst_b = 1'b1;
    tick();
    check_val("rs_sb", sb_b, 1'b0);
    check_val("rs_data_clr", bus_b, 8'h00);
    check_val("rs_busy", busy_b, 1'b0);
    check_val("rs_ack_clr", ack0_b, 1'b0);
    rst_b = 1'b0;
    tick();
    check_val("rs_reack", ack0_b, 1'b1);
    check_val("rs_redata", bus_b, 8'h99);
    req0_b = 1'b0;
    for (int c = 0; c < 20 && busy_b; c++) tick();
    check_val("rs_drain", busy_b, 1'b0);

    // ---------------- request raised in GAP and dropped before IDLE ----------------
    req0_c = 1'b1;
    data0_c = 8'hA5;
    tick();
    check_val("gp_ack0", ack0_c, 1'b1);
    check_val("gp_data", bus_c, 8'hA5);
    req0_c = 1'b0;
    tick();
    check_val("gp_strobe", sb_c, 1'b1);
    tick();
    check_val("gp_gap_sb", sb_c, 1'b0);
    req1_c = 1'b1;
    data1_c = 8'h3C;
    tick();
    check_val("gp_gap_busy", busy_c, 1'b1);
    check_val("gp_no_ack_in_gap", ack1_c, 1'b0);
    tick();
    check_val("gp_gap_busy2", busy_c, 1'b1);
    req1_c = 1'b0;
    tick();
    check_val("gp_idle", busy_c, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("gp_no_ack1", ack1_c, 1'b0);
      check_val("gp_data_hold", bus_c, 8'hA5);
      check_val("gp_stay_idle", busy_c, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
